// File: rtl/ps2_transmit.sv
// PS/2 host-to-device byte transmitter (inhibit, request-to-send, shift, ACK).
// Optional watchdog: define PS2_TX_TIMEOUT_EN.
// Ports: clock_50, reset_n (async, active low), send_data/send_en (request),
//   busy/done/error (status), ps2_clk_i/ps2_dat_i (raw line levels),
//   ps2_clk_oe/ps2_dat_oe (1 = pull line low, 0 = release).
module ps2_transmit #(
   parameter int unsigned INHIBIT_CYCLES = 6000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       clock_50,
   input  logic       reset_n,
   input  logic [7:0] send_data,
   input  logic       send_en,
   output logic       busy,
   output logic       done,
   output logic       error,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [IW-1:0] INH_END  = IW'(INHIBIT_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQUEST,
      SHIFT,
      ACK,
      RELEASE
   } state_t;

   state_t        state;
   logic          clk_s1;
   logic          clk_s2;
   logic          dat_s1;
   logic          dat_s2;
   logic [3:0]    clk_hist;
   logic          clk_f;
   logic          clk_f_d;
   logic          fall;
   logic          line_idle;
   logic [IW-1:0] icnt;
   logic [3:0]    bcnt;
   logic [3:0]    bnext;
   logic [7:0]    tx_data;
   logic          tx_par;
   logic [9:0]    frame;
   logic          ack_ok;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] to_cnt;
`endif

   // Synchronizers plus a clock filter that only moves after
   // four equal consecutive samples of the synchronized clock.
   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
         clk_hist <= 4'hF;
         clk_f    <= 1'b1;
         clk_f_d  <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk_i;
         clk_s2   <= clk_s1;
         dat_s1   <= ps2_dat_i;
         dat_s2   <= dat_s1;
         clk_hist <= {clk_hist[2:0], clk_s2};
         if (&clk_hist)
            clk_f <= 1'b1;
         else if (~|clk_hist)
            clk_f <= 1'b0;
         clk_f_d  <= clk_f;
      end
   end

   assign fall      = clk_f_d & ~clk_f;
   assign line_idle = clk_f & dat_s2;

   // Frame bit index: 0-7 data LSB first, 8 parity, 9 stop.
   assign frame = {1'b1, tx_par, tx_data};
   assign bnext = bcnt + 4'd1;

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         icnt       <= '0;
         bcnt       <= '0;
         tx_data    <= '0;
         tx_par     <= 1'b0;
         ack_ok     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
         to_cnt     <= '0;
`endif
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         unique case (state)
            IDLE: begin
               if (send_en) begin
                  tx_data    <= send_data;
                  tx_par     <= ~^send_data;
                  busy       <= 1'b1;
                  ps2_clk_oe <= 1'b1;
                  ps2_dat_oe <= 1'b0;
                  icnt       <= '0;
                  state      <= INHIBIT;
               end
            end
            INHIBIT: begin
               // Clock held low; the start bit joins for the last cycle.
               if (icnt == INH_END) begin
                  ps2_clk_oe <= 1'b0;
                  state      <= REQUEST;
               end else begin
                  if (icnt == INH_LAST)
                     ps2_dat_oe <= 1'b1;
                  icnt <= icnt + 1'b1;
               end
            end
            REQUEST: begin
               if (fall) begin
                  ps2_dat_oe <= ~tx_data[0];
                  bcnt       <= '0;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               // bcnt is the bit currently on the line.
               if (fall) begin
                  ps2_dat_oe <= ~frame[bnext];
                  bcnt       <= bnext;
                  if (bcnt == 4'd8)
                     state <= ACK;
               end
            end
            ACK: begin
               if (fall) begin
                  ack_ok <= ~dat_s2;
                  state  <= RELEASE;
               end
            end
            RELEASE: begin
               ps2_clk_oe <= 1'b0;
               ps2_dat_oe <= 1'b0;
               if (line_idle) begin
                  done  <= ack_ok;
                  error <= ~ack_ok;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
`ifdef PS2_TX_TIMEOUT_EN
         // Watchdog overrides whatever the state logic chose this cycle.
         if (state == IDLE) begin
            to_cnt <= '0;
         end else if (to_cnt == TO_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            ack_ok     <= 1'b0;
            if (line_idle) begin
               done  <= 1'b0;
               error <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end else begin
               done  <= 1'b0;
               error <= 1'b0;
               state <= RELEASE;
            end
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
`endif
      end
   end

endmodule
